// File: rtl/bep_pkg.sv
// rtl/bep_pkg.sv - shared types and defaults for the preamble aligner
// Purpose: FSM state enum and default preamble/payload/timeout constants
//          used by preamble_sync and preamble_matcher.
// Ports:   none (package).
package bep_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  localparam int         BEP_PREAMBLE_LEN   = 8;
  localparam logic [7:0] BEP_PREAMBLE       = 8'hD5;
  localparam int         BEP_PAYLOAD_BITS   = 32;
  localparam int         BEP_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/preamble_matcher.sv
// rtl/preamble_matcher.sv - sliding preamble window, fill counter and compare
// Purpose: shifts recovered bits into a LEN-bit window (MSB received first),
//          tracks how many bits have been seen (saturating at LEN) and flags a
//          match on the next-window value. Build macro PREAMBLE_SYNC_TOLERANT_EN
//          accepts a Hamming distance of up to 1; otherwise exact match only.
// Ports:   clock, reset   clock and asynchronous active-high reset
//          clear_i        synchronous clear of window and fill (wins over shift)
//          shift_i        shift bit_i into the window this cycle
//          bit_i          bit to shift in
//          match_o        combinational: shifting now completes a preamble
module preamble_matcher
  import bep_pkg::*;
#(
  parameter int               LEN     = BEP_PREAMBLE_LEN,
  parameter logic [LEN-1:0]   PATTERN = BEP_PREAMBLE
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic shift_i,
  input  logic bit_i,
  output logic match_o
);

  localparam int FW = $clog2(LEN + 1);

`ifdef PREAMBLE_SYNC_TOLERANT_EN
  localparam int unsigned MAX_DIST = 1;
`else
  localparam int unsigned MAX_DIST = 0;
`endif

  logic [LEN-1:0] window_q, window_d;
  logic [FW-1:0]  fill_q, fill_d;

  function automatic int unsigned popcount(input logic [LEN-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < LEN; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

  always_comb begin
    window_d = {window_q[LEN-2:0], bit_i};
    fill_d   = (fill_q == FW'(LEN)) ? fill_q : fill_q + 1'b1;
    // Compare against the window as it will be after this bit, so the match
    // is known in the event cycle and the FSM can respond with latency 1.
    match_o  = shift_i && (fill_d == FW'(LEN)) &&
               (popcount(window_d ^ PATTERN) <= MAX_DIST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (clear_i) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (shift_i) begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/preamble_sync.sv
// rtl/preamble_sync.sv - preamble-gated payload window between bit recovery and buffer
// Purpose: hunts for PREAMBLE in the recovered bit stream, then forwards exactly
//          PAYLOAD_BITS bits with a per-bit strobe, aborting if the gap between
//          payload bits reaches TIMEOUT_CYCLES. Optional build macro
//          PREAMBLE_SYNC_TOLERANT_EN (in preamble_matcher) allows a 1-bit error.
// Ports:   clock, reset          clock and asynchronous active-high reset
//          bit_clock, bit_data   recovered bit clock level and bit value
//          out_clock, out_data   per-bit strobe and held forwarded bit
//          transmission_begin    pulse on preamble match (resets downstream buffer)
//          frame_done            pulse with the last payload out_clock
//          frame_abort           pulse on payload timeout
//          locked                high while forwarding payload
module preamble_sync
  import bep_pkg::*;
#(
  parameter int                      PREAMBLE_LEN   = BEP_PREAMBLE_LEN,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE       = BEP_PREAMBLE,
  parameter int                      PAYLOAD_BITS   = BEP_PAYLOAD_BITS,
  parameter int                      TIMEOUT_CYCLES = BEP_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic bit_clock,
  input  logic bit_data,
  output logic out_clock,
  output logic out_data,
  output logic transmission_begin,
  output logic frame_done,
  output logic frame_abort,
  output logic locked
);

  localparam int BCW = $clog2(PAYLOAD_BITS);
  localparam int ICW = $clog2(TIMEOUT_CYCLES);

  state_e         state_q;
  logic           bit_prev_q;
  logic [BCW-1:0] bit_cnt_q;
  logic [ICW-1:0] idle_cnt_q;
  logic           out_clock_q, out_data_q, begin_q, done_q, abort_q, locked_q;

  logic bit_event;
  logic match;

  assign bit_event = bit_clock & ~bit_prev_q;

  // Window is held cleared for the whole payload, so returning to HUNT always
  // starts from an empty window and payload bits can never complete a preamble.
  preamble_matcher #(
    .LEN     (PREAMBLE_LEN),
    .PATTERN (PREAMBLE)
  ) u_matcher (
    .clock   (clock),
    .reset   (reset),
    .clear_i (state_q == PAYLOAD),
    .shift_i (bit_event && (state_q == HUNT)),
    .bit_i   (bit_data),
    .match_o (match)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      bit_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      out_clock_q <= 1'b0;
      out_data_q  <= 1'b0;
      begin_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      bit_prev_q  <= bit_clock;
      out_clock_q <= 1'b0;
      begin_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      case (state_q)
        HUNT: begin
          if (match) begin
            begin_q    <= 1'b1;
            locked_q   <= 1'b1;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            state_q    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          // A bit arriving in the would-be timeout cycle takes priority.
          if (bit_event) begin
            out_data_q  <= bit_data;
            out_clock_q <= 1'b1;
            idle_cnt_q  <= '0;
            if (bit_cnt_q == BCW'(PAYLOAD_BITS - 1)) begin
              done_q   <= 1'b1;
              locked_q <= 1'b0;
              state_q  <= HUNT;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (idle_cnt_q == ICW'(TIMEOUT_CYCLES - 2)) begin
            // Count would reach TIMEOUT_CYCLES-1 this cycle: give up on the frame.
            abort_q  <= 1'b1;
            locked_q <= 1'b0;
            state_q  <= HUNT;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign out_clock          = out_clock_q;
  assign out_data           = out_data_q;
  assign transmission_begin = begin_q;
  assign frame_done         = done_q;
  assign frame_abort        = abort_q;
  assign locked             = locked_q;

endmodule

// File: tb/tb_preamble_sync.sv
// tb/tb_preamble_sync.sv - self-checking bench for preamble_sync
module tb_preamble_sync;
  import bep_pkg::*;

  localparam int TO = BEP_TIMEOUT_CYCLES;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bit_clock = 1'b0;
  logic bit_data = 1'b0;
  logic out_clock, out_data, transmission_begin, frame_done, frame_abort, locked;

  preamble_sync dut (
    .clock              (clock),
    .reset              (reset),
    .bit_clock          (bit_clock),
    .bit_data           (bit_data),
    .out_clock          (out_clock),
    .out_data           (out_data),
    .transmission_begin (transmission_begin),
    .frame_done         (frame_done),
    .frame_abort        (frame_abort),
    .locked             (locked)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];
  int out_cnt, tb_cnt, done_cnt, abort_cnt;
  int tb_cyc, done_cyc, abort_cyc, last_ev;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (out_clock) begin
        out_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_out_clock", 32'd1, 32'd0);
        else check_eq("out_data", {31'b0, out_data}, {31'b0, exp_q.pop_front()});
      end
      if (transmission_begin) begin
        tb_cnt++;
        tb_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_with_out_clock", {31'b0, out_clock}, 32'd1);
      end
      if (frame_abort) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    exp_q.delete();
    out_cnt = 0; tb_cnt = 0; done_cnt = 0; abort_cnt = 0;
    tb_cyc = -1; done_cyc = -1; abort_cyc = -1; last_ev = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bit_clock = 1'b0;
    bit_data = 1'b0;
    clear_stats();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(posedge clock); #1;
    bit_clock = 1'b1;
    bit_data  = b;
    last_ev   = cyc;
    @(posedge clock); #1;
    bit_clock = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int n, input bit push);
    for (int i = n - 1; i >= 0; i--) begin
      if (push) exp_q.push_back(w[i]);
      send_bit(w[i]);
    end
  endtask

  task automatic wait_abort(input int budget);
    int n;
    n = 0;
    while (abort_cnt == 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (abort_cnt == 0) check_eq("abort_wait_expired", 32'd0, 32'd1);
  endtask

  initial begin
    int e5;
    int target;
    clear_stats();

    // 1: reset state, D5 + CAFEBABE
    do_reset();
    check_eq("rst_out_clock", {31'b0, out_clock}, 32'd0);
    check_eq("rst_out_data", {31'b0, out_data}, 32'd0);
    check_eq("rst_begin", {31'b0, transmission_begin}, 32'd0);
    check_eq("rst_done", {31'b0, frame_done}, 32'd0);
    check_eq("rst_abort", {31'b0, frame_abort}, 32'd0);
    check_eq("rst_locked", {31'b0, locked}, 32'd0);
    send_word(32'h0000_00D5, 8, 1'b0);
    check_eq("t1_begin_cnt", tb_cnt, 1);
    check_eq("t1_begin_cyc", tb_cyc, last_ev + 1);
    check_eq("t1_locked", {31'b0, locked}, 32'd1);
    send_word(32'hCAFE_BABE, 32, 1'b1);
    check_eq("t1_out_cnt", out_cnt, 32);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_done_cyc", done_cyc, last_ev + 1);
    check_eq("t1_queue_empty", exp_q.size(), 0);
    check_eq("t1_unlocked", {31'b0, locked}, 32'd0);

    // 2: one-bit-flipped preamble
    do_reset();
    send_word(32'h0000_00D4, 8, 1'b0);
`ifdef PREAMBLE_SYNC_TOLERANT_EN
    check_eq("t2_begin_cnt", tb_cnt, 1);
    check_eq("t2_begin_cyc", tb_cyc, last_ev + 1);
    send_word(32'h00FF_00FF, 32, 1'b1);
    check_eq("t2_out_cnt", out_cnt, 32);
    check_eq("t2_done_cnt", done_cnt, 1);
`else
    send_word(32'h00FF_00FF, 32, 1'b0);
    check_eq("t2_begin_cnt", tb_cnt, 0);
    check_eq("t2_out_cnt", out_cnt, 0);
    check_eq("t2_locked", {31'b0, locked}, 32'd0);
`endif

    // 3: timeout after 5 payload bits, then relock
    do_reset();
    send_word(32'h0000_00D5, 8, 1'b0);
    send_word(32'h0000_0015, 5, 1'b1);
    e5 = last_ev;
    wait_abort(TO + 100);
    check_eq("t3_abort_cyc", abort_cyc, e5 + TO);
    check_eq("t3_abort_cnt", abort_cnt, 1);
    check_eq("t3_done_cnt", done_cnt, 0);
    check_eq("t3_locked", {31'b0, locked}, 32'd0);
    check_eq("t3_out_cnt", out_cnt, 5);
    send_word(32'h0000_00D5, 8, 1'b0);
    check_eq("t3_relock", tb_cnt, 2);

    // 4: bit lands in the would-be timeout cycle
    do_reset();
    send_word(32'h0000_00D5, 8, 1'b0);
    send_word(32'h0000_000A, 5, 1'b1);
    e5 = last_ev;
    target = e5 + TO - 2;
    while (cyc < target) begin
      @(posedge clock); #1;
    end
    exp_q.push_back(1'b1);
    send_bit(1'b1);
    repeat (10) @(posedge clock);
    #1;
    check_eq("t4_no_abort", abort_cnt, 0);
    check_eq("t4_out_cnt", out_cnt, 6);
    check_eq("t4_locked", {31'b0, locked}, 32'd1);
    wait_abort(TO + 100);
    check_eq("t4_restart_cyc", abort_cyc, last_ev + TO);

    // 5: async reset mid-payload at bit 17
    do_reset();
    send_word(32'h0000_00D5, 8, 1'b0);
    send_word(32'h0001_FFFF, 17, 1'b1);
    check_eq("t5_pre_queue", exp_q.size(), 0);
    @(posedge clock); #1;
    bit_clock = 1'b1;
    bit_data  = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check_eq("t5_out_clock", {31'b0, out_clock}, 32'd0);
    check_eq("t5_out_data", {31'b0, out_data}, 32'd0);
    check_eq("t5_locked", {31'b0, locked}, 32'd0);
    check_eq("t5_abort", {31'b0, frame_abort}, 32'd0);
    do_reset();
    send_word(32'h0000_00D5, 8, 1'b0);
    send_word(32'hCAFE_BABE, 32, 1'b1);
    check_eq("t5_replay_done", done_cnt, 1);
    check_eq("t5_replay_out_cnt", out_cnt, 32);

    // 6: preamble pattern inside the payload
    do_reset();
    send_word(32'h0000_00D5, 8, 1'b0);
    send_word(32'h12D5_3456, 32, 1'b1);
    check_eq("t6_begin_cnt", tb_cnt, 1);
    check_eq("t6_done_cnt", done_cnt, 1);
    check_eq("t6_done_cyc", done_cyc, last_ev + 1);
    check_eq("t6_out_cnt", out_cnt, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
